alu_issue_seq: RTL and testbench

Upstream issue stage for the 8-bit ALU. Accepts 9-bit register-to-register instructions over a valid/ready handshake, reads operands from a local 4×8 register file, and drives the ALU operand, opcode and enable inputs. It then captures the ALU result and zero output and writes the result back into the register file. The ALU itself is combinational and sits outside this block, wired at the top level between `alu_src1`/`alu_src2`/`alu_op`/`alu_en` and `alu_dst`/`alu_zero`.

---
 rtl/alu_pkg.sv | 51 +++++
 rtl/alu_issue_seq_if.sv | 42 ++++
 rtl/alu_regfile.sv | 54 +++++
 rtl/alu_issue_seq.sv | 123 ++++++++++++
 tb/tb_alu_issue_seq.sv | 288 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU issue stage: opcodes, instruction layout and FSM states.
package alu_pkg;

    // ALU opcodes (interpreted by the external ALU only)
    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_SUB  = 3'b001;
    localparam logic [2:0] OP_SHL  = 3'b010;
    localparam logic [2:0] OP_PASS = 3'b011;
    localparam logic [2:0] OP_AND  = 3'b100;
    localparam logic [2:0] OP_OR   = 3'b101;
    localparam logic [2:0] OP_XOR  = 3'b110;
    localparam logic [2:0] OP_NOT  = 3'b111;

    // Instruction layout: op[8:6] rd[5:4] rs1[3:2] rs2[1:0]
    localparam int unsigned INSTR_W = 9;
    localparam int unsigned OP_MSB  = 8;
    localparam int unsigned OP_LSB  = 6;
    localparam int unsigned RD_MSB  = 5;
    localparam int unsigned RD_LSB  = 4;
    localparam int unsigned RS1_MSB = 3;
    localparam int unsigned RS1_LSB = 2;
    localparam int unsigned RS2_MSB = 1;
    localparam int unsigned RS2_LSB = 0;

    // Register address width (four registers)
    localparam int unsigned REG_AW = 2;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_READ = 2'd1,
        S_EXEC = 2'd2,
        S_WB   = 2'd3
    } state_e;

    typedef struct packed {
        logic [2:0]        op;
        logic [REG_AW-1:0] rd;
        logic [REG_AW-1:0] rs1;
        logic [REG_AW-1:0] rs2;
    } instr_t;

    function automatic instr_t decode_instr(input logic [INSTR_W-1:0] raw);
        instr_t d;
        d.op  = raw[OP_MSB:OP_LSB];
        d.rd  = raw[RD_MSB:RD_LSB];
        d.rs1 = raw[RS1_MSB:RS1_LSB];
        d.rs2 = raw[RS2_MSB:RS2_LSB];
        return d;
    endfunction

endpackage

// File: rtl/alu_issue_seq_if.sv
// Bundle of the issue stage's instruction, load, ALU, result and debug signals.
interface alu_issue_seq_if
    import alu_pkg::*;
#(
    parameter int unsigned W = 8
);
    logic                  in_valid;
    logic [INSTR_W-1:0]    in_instr;
    logic                  in_ready;
    logic                  ld_valid;
    logic [REG_AW-1:0]     ld_addr;
    logic [W-1:0]          ld_data;
    logic                  ld_ready;
    logic [W-1:0]          alu_src1;
    logic [W-1:0]          alu_src2;
    logic [2:0]            alu_op;
    logic                  alu_en;
    logic [W-1:0]          alu_dst;
    logic                  alu_zero;
    logic                  res_valid;
    logic [W-1:0]          res_data;
    logic [REG_AW-1:0]     res_rd;
    logic                  zero_flag;
    logic [7:0]            instr_cnt;
    logic [REG_AW-1:0]     dbg_addr;
    logic [W-1:0]          dbg_data;

    // Issue-stage side
    modport slave (
        input  in_valid, in_instr, ld_valid, ld_addr, ld_data, alu_dst, alu_zero, dbg_addr,
        output in_ready, ld_ready, alu_src1, alu_src2, alu_op, alu_en,
        output res_valid, res_data, res_rd, zero_flag, instr_cnt, dbg_data
    );

    // Instruction source / ALU / observer side
    modport master (
        output in_valid, in_instr, ld_valid, ld_addr, ld_data, alu_dst, alu_zero, dbg_addr,
        input  in_ready, ld_ready, alu_src1, alu_src2, alu_op, alu_en,
        input  res_valid, res_data, res_rd, zero_flag, instr_cnt, dbg_data
    );

endinterface

// File: rtl/alu_regfile.sv
// Register file: NREG x W, two operand read ports, one debug read port, one shared write port.
module alu_regfile
    import alu_pkg::*;
#(
    parameter int unsigned NREG = 4,
    parameter int unsigned W    = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_wb_en,
    input  logic [REG_AW-1:0] i_wb_addr,
    input  logic [W-1:0]      i_wb_data,
    input  logic              i_ld_en,
    input  logic [REG_AW-1:0] i_ld_addr,
    input  logic [W-1:0]      i_ld_data,
    input  logic [REG_AW-1:0] i_rd1_addr,
    input  logic [REG_AW-1:0] i_rd2_addr,
    input  logic [REG_AW-1:0] i_dbg_addr,
    output logic [W-1:0]      o_rd1_data,
    output logic [W-1:0]      o_rd2_data,
    output logic [W-1:0]      o_dbg_data
);
    logic [W-1:0]      r_mem [NREG];
    logic              w_we;
    logic [REG_AW-1:0] w_waddr;
    logic [W-1:0]      w_wdata;

    // Writeback and load never coincide (loads are held off during writeback)
    always_comb begin
        w_we    = i_wb_en | i_ld_en;
        w_waddr = i_ld_addr;
        w_wdata = i_ld_data;
        if (i_wb_en) begin
            w_waddr = i_wb_addr;
            w_wdata = i_wb_data;
        end
    end

    // Storage update
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < NREG; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_we) begin
            r_mem[w_waddr] <= w_wdata;
        end
    end

    assign o_rd1_data = r_mem[i_rd1_addr];
    assign o_rd2_data = r_mem[i_rd2_addr];
    assign o_dbg_data = r_mem[i_dbg_addr];

endmodule

// File: rtl/alu_issue_seq.sv
// Issue stage: accepts one instruction, reads operands, drives the external ALU,
// captures its result and writes it back. One instruction every four cycles.
module alu_issue_seq
    import alu_pkg::*;
#(
    parameter int unsigned NREG = 4,
    parameter int unsigned W    = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    alu_issue_seq_if.slave bus
);
    state_e            r_state;
    instr_t            r_instr;
    logic [W-1:0]      r_src1;
    logic [W-1:0]      r_src2;
    logic [2:0]        r_op;
    logic              r_en;
    logic [W-1:0]      r_res;
    logic              r_res_zero;
    logic              r_res_valid;
    logic [W-1:0]      r_res_data;
    logic [REG_AW-1:0] r_res_rd;
    logic              r_zero_flag;
    logic [7:0]        r_cnt;

    logic              w_in_ready;
    logic              w_ld_ready;
    logic              w_wb_en;
    logic              w_ld_en;
    logic [W-1:0]      w_rs1_data;
    logic [W-1:0]      w_rs2_data;

    assign w_in_ready = (r_state == S_IDLE);
    assign w_ld_ready = (r_state != S_WB);
    assign w_wb_en    = (r_state == S_WB);
    assign w_ld_en    = bus.ld_valid & w_ld_ready;

    alu_regfile #(
        .NREG (NREG),
        .W    (W)
    ) u_regfile (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_wb_en    (w_wb_en),
        .i_wb_addr  (r_instr.rd),
        .i_wb_data  (r_res),
        .i_ld_en    (w_ld_en),
        .i_ld_addr  (bus.ld_addr),
        .i_ld_data  (bus.ld_data),
        .i_rd1_addr (r_instr.rs1),
        .i_rd2_addr (r_instr.rs2),
        .i_dbg_addr (bus.dbg_addr),
        .o_rd1_data (w_rs1_data),
        .o_rd2_data (w_rs2_data),
        .o_dbg_data (bus.dbg_data)
    );

    // Issue FSM with all outputs registered
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_instr     <= '0;
            r_src1      <= '0;
            r_src2      <= '0;
            r_op        <= '0;
            r_en        <= 1'b0;
            r_res       <= '0;
            r_res_zero  <= 1'b0;
            r_res_valid <= 1'b0;
            r_res_data  <= '0;
            r_res_rd    <= '0;
            r_zero_flag <= 1'b0;
            r_cnt       <= '0;
        end else begin
            r_res_valid <= 1'b0;
            unique case (r_state)
                S_IDLE: begin
                    if (bus.in_valid) begin
                        r_instr <= decode_instr(bus.in_instr);
                        r_state <= S_READ;
                    end
                end
                S_READ: begin
                    // Loads up to and including the accept edge are visible here
                    r_src1  <= w_rs1_data;
                    r_src2  <= w_rs2_data;
                    r_op    <= r_instr.op;
                    r_en    <= 1'b1;
                    r_state <= S_EXEC;
                end
                S_EXEC: begin
                    r_res      <= bus.alu_dst;
                    r_res_zero <= bus.alu_zero;
                    r_en       <= 1'b0;
                    r_state    <= S_WB;
                end
                S_WB: begin
                    r_res_valid <= 1'b1;
                    r_res_data  <= r_res;
                    r_res_rd    <= r_instr.rd;
                    r_zero_flag <= r_res_zero;
                    r_cnt       <= r_cnt + 8'd1;
                    r_state     <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.ld_ready  = w_ld_ready;
    assign bus.alu_src1  = r_src1;
    assign bus.alu_src2  = r_src2;
    assign bus.alu_op    = r_op;
    assign bus.alu_en    = r_en;
    assign bus.res_valid = r_res_valid;
    assign bus.res_data  = r_res_data;
    assign bus.res_rd    = r_res_rd;
    assign bus.zero_flag = r_zero_flag;
    assign bus.instr_cnt = r_cnt;

endmodule

// File: tb/tb_alu_issue_seq.sv
// Self-checking bench for alu_issue_seq: directed cases plus randomized traffic
// against a latency-based reference model.
module tb_alu_issue_seq;
    import alu_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    alu_issue_seq_if #(.W(8)) bus ();

    alu_issue_seq #(
        .NREG (4),
        .W    (8)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Behaviour of the external ALU
    function automatic logic [7:0] alu_ref(input logic [2:0] op, input logic [7:0] a,
                                           input logic [7:0] b);
        case (op)
            OP_ADD:  return a + b;
            OP_SUB:  return a - b;
            OP_SHL:  return a << 1;
            OP_PASS: return a;
            OP_AND:  return a & b;
            OP_OR:   return a | b;
            OP_XOR:  return a ^ b;
            default: return ~a;
        endcase
    endfunction

    assign bus.alu_dst  = bus.alu_en ? alu_ref(bus.alu_op, bus.alu_src1, bus.alu_src2) : 8'h00;
    assign bus.alu_zero = (bus.alu_dst == 8'h00);

    function automatic logic [8:0] enc(input logic [2:0] op, input logic [1:0] rd,
                                       input logic [1:0] rs1, input logic [1:0] rs2);
        return {op, rd, rs1, rs2};
    endfunction

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    // Reference model: instruction accepted at edge m_acc; operands sampled at m_acc+1,
    // result at m_acc+2, writeback at m_acc+3.
    logic [7:0] m_rf [4];
    bit         m_busy;
    int         m_acc;
    int         edge_n = 0;
    logic [8:0] m_instr;
    logic [7:0] m_src1, m_src2, m_res, m_wb_data, m_cnt;
    logic [2:0] m_op;
    logic [1:0] m_wb_rd;
    bit         m_wb_pulse, m_zero;

    task automatic model_reset();
        for (int i = 0; i < 4; i++) m_rf[i] = 8'h00;
        m_busy = 0; m_acc = 0; m_instr = '0;
        m_src1 = '0; m_src2 = '0; m_op = '0; m_res = '0;
        m_wb_pulse = 0; m_wb_data = '0; m_wb_rd = '0; m_zero = 0; m_cnt = '0;
    endtask

    task automatic model_edge();
        int age;
        bit was_busy;
        bit ld_blocked;
        edge_n++;
        m_wb_pulse = 0;
        was_busy = m_busy;
        age = edge_n - m_acc;
        ld_blocked = m_busy && age == 3;
        if (m_busy && age == 1) begin
            m_src1 = m_rf[m_instr[3:2]];
            m_src2 = m_rf[m_instr[1:0]];
            m_op   = m_instr[8:6];
        end
        if (m_busy && age == 2) m_res = alu_ref(m_op, m_src1, m_src2);
        if (m_busy && age == 3) begin
            m_rf[m_instr[5:4]] = m_res;
            m_wb_pulse = 1;
            m_wb_data  = m_res;
            m_wb_rd    = m_instr[5:4];
            m_zero     = (m_res == 8'h00);
            m_cnt      = m_cnt + 8'd1;
            m_busy     = 0;
        end
        if (bus.ld_valid && !ld_blocked) m_rf[bus.ld_addr] = bus.ld_data;
        if (!was_busy && bus.in_valid) begin
            m_busy  = 1;
            m_acc   = edge_n;
            m_instr = bus.in_instr;
        end
    endtask

    task automatic check_all();
        int age;
        age = edge_n - m_acc;
        check_eq("in_ready", 32'(bus.in_ready), 32'(!m_busy));
        check_eq("ld_ready", 32'(bus.ld_ready), 32'(!(m_busy && age == 2)));
        check_eq("alu_en", 32'(bus.alu_en), 32'(m_busy && age == 1));
        check_eq("alu_src1", 32'(bus.alu_src1), 32'(m_src1));
        check_eq("alu_src2", 32'(bus.alu_src2), 32'(m_src2));
        check_eq("alu_op", 32'(bus.alu_op), 32'(m_op));
        check_eq("res_valid", 32'(bus.res_valid), 32'(m_wb_pulse));
        if (m_wb_pulse) begin
            check_eq("res_data", 32'(bus.res_data), 32'(m_wb_data));
            check_eq("res_rd", 32'(bus.res_rd), 32'(m_wb_rd));
        end
        check_eq("zero_flag", 32'(bus.zero_flag), 32'(m_zero));
        check_eq("instr_cnt", 32'(bus.instr_cnt), 32'(m_cnt));
        check_eq("dbg_data", 32'(bus.dbg_data), 32'(m_rf[bus.dbg_addr]));
    endtask

    // One clock: model follows the edge, outputs checked mid-low-phase
    task automatic step();
        @(posedge clk);
        if (rst_n) model_edge();
        @(negedge clk);
        bus.dbg_addr = 2'($urandom_range(0, 3));
        #1;
        check_all();
    endtask

    task automatic do_load(input logic [1:0] addr, input logic [7:0] data);
        bus.ld_valid = 1'b1; bus.ld_addr = addr; bus.ld_data = data;
        step();
        bus.ld_valid = 1'b0;
    endtask

    task automatic accept(input logic [8:0] ins);
        bit acc;
        bit done;
        done = 0;
        bus.in_valid = 1'b1;
        bus.in_instr = ins;
        for (int n = 0; n < 8 && !done; n++) begin
            acc = !m_busy;
            step();
            if (acc) done = 1;
        end
        check_eq("accept_seen", 32'(done), 32'd1);
        bus.in_valid = 1'b0;
        bus.in_instr = 9'($urandom);
    endtask

    task automatic issue(input logic [8:0] ins, input logic [7:0] exp_data, input bit exp_zero);
        int lat;
        bit seen;
        accept(ins);
        lat = 0; seen = 0;
        for (int n = 0; n < 8 && !seen; n++) begin
            step();
            lat++;
            if (bus.res_valid) seen = 1;
        end
        check_eq("wb_latency", 32'(lat), 32'd3);
        check_eq("res_data_dir", 32'(bus.res_data), 32'(exp_data));
        check_eq("res_rd_dir", 32'(bus.res_rd), 32'(ins[5:4]));
        check_eq("zero_dir", 32'(bus.zero_flag), 32'(exp_zero));
    endtask

    logic [8:0] pipe_q [3];
    logic [7:0] cnt_before;
    int         idx, pulses, last_c;
    bit         acc_b;

    initial begin
        bus.in_valid = 1'b0; bus.in_instr = '0;
        bus.ld_valid = 1'b0; bus.ld_addr = '0; bus.ld_data = '0; bus.dbg_addr = '0;
        model_reset();
        @(negedge clk);
        #1 check_all();
        @(negedge clk);
        rst_n = 1'b1;
        #1 check_all();
        for (int r = 0; r < 4; r++) begin
            bus.dbg_addr = 2'(r);
            #1 check_eq("reset_rf", 32'(bus.dbg_data), 32'd0);
        end

        // ADD / SUB / SHL with wrap and zero cases
        do_load(2'd0, 8'h05);
        do_load(2'd1, 8'h03);
        issue(enc(OP_ADD, 2'd2, 2'd0, 2'd1), 8'h08, 1'b0);
        bus.dbg_addr = 2'd2;
        #1 check_eq("dbg_r2", 32'(bus.dbg_data), 32'h08);
        cnt_before = bus.instr_cnt;
        issue(enc(OP_SUB, 2'd3, 2'd1, 2'd0), 8'hFE, 1'b0);
        check_eq("cnt_inc1", 32'(bus.instr_cnt), 32'(cnt_before + 8'd1));
        issue(enc(OP_SUB, 2'd3, 2'd0, 2'd0), 8'h00, 1'b1);
        check_eq("cnt_inc2", 32'(bus.instr_cnt), 32'(cnt_before + 8'd2));
        do_load(2'd0, 8'h80);
        issue(enc(OP_SHL, 2'd1, 2'd0, 2'd3), 8'h00, 1'b1);

        // Three queued instructions with in_valid held high
        pipe_q[0] = enc(OP_ADD, 2'd0, 2'd2, 2'd3);
        pipe_q[1] = enc(OP_XOR, 2'd1, 2'd0, 2'd2);
        pipe_q[2] = enc(OP_OR,  2'd2, 2'd1, 2'd0);
        idx = 0; pulses = 0; last_c = -1;
        bus.in_valid = 1'b1; bus.in_instr = pipe_q[0];
        for (int c = 0; c < 16; c++) begin
            acc_b = !m_busy && bus.in_valid;
            step();
            if (acc_b) begin
                idx++;
                if (idx < 3) bus.in_instr = pipe_q[idx];
                else bus.in_valid = 1'b0;
            end
            if (bus.res_valid) begin
                pulses++;
                if (last_c >= 0) check_eq("pipe_gap", 32'(c - last_c), 32'd4);
                last_c = c;
            end
        end
        check_eq("pipe_pulses", 32'(pulses), 32'd3);

        // Load to r2 during writeback of r2 is stalled, then lands
        accept(enc(OP_ADD, 2'd2, 2'd0, 2'd1));
        idx = 0;
        while (!(m_busy && (edge_n - m_acc) == 2) && idx < 10) begin
            step();
            idx++;
        end
        check_eq("steps_to_wb", 32'(idx), 32'd2);
        bus.ld_valid = 1'b1; bus.ld_addr = 2'd2; bus.ld_data = 8'hA5;
        #1 check_eq("ld_ready_in_wb", 32'(bus.ld_ready), 32'd0);
        step();
        step();
        bus.ld_valid = 1'b0;
        bus.dbg_addr = 2'd2;
        #1 check_eq("r2_after_stall", 32'(bus.dbg_data), 32'hA5);

        // Reset while in EXEC discards the instruction
        accept(enc(OP_ADD, 2'd3, 2'd0, 2'd1));
        step();
        check_eq("in_exec_en", 32'(bus.alu_en), 32'd1);
        rst_n = 1'b0;
        model_reset();
        #1 check_all();
        for (int r = 0; r < 4; r++) begin
            bus.dbg_addr = 2'(r);
            #1 check_eq("midrst_rf", 32'(bus.dbg_data), 32'd0);
        end
        step();
        step();
        rst_n = 1'b1;
        #1 check_eq("in_ready_after_rst", 32'(bus.in_ready), 32'd1);
        step();

        // Back-to-back traffic long enough to wrap instr_cnt, with random loads
        bus.in_valid = 1'b1;
        for (int c = 0; c < 1050; c++) begin
            bus.in_instr = 9'($urandom);
            bus.ld_valid = 1'($urandom);
            bus.ld_addr  = 2'($urandom);
            bus.ld_data  = 8'($urandom);
            step();
        end

        // Fully random handshakes
        for (int c = 0; c < 400; c++) begin
            bus.in_valid = ($urandom_range(0, 3) == 0);
            bus.in_instr = 9'($urandom);
            bus.ld_valid = 1'($urandom);
            bus.ld_addr  = 2'($urandom);
            bus.ld_data  = 8'($urandom);
            step();
        end
        bus.in_valid = 1'b0;
        bus.ld_valid = 1'b0;
        repeat (4) step();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
